// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod.
// The master drives the controls and the slave (the counter) returns count and flags.
interface counter_updown_mod_if #(
  parameter int N = 8
) ();
  logic         en;
  logic         up_down;
  logic         clear;
  logic         load;
  logic [N-1:0] load_val;
  logic         ovf_clr;
  logic [N-1:0] count;
  logic         tc;
  logic         wrap;
  logic         ovf;

  modport master (
    output en, up_down, clear, load, load_val, ovf_clr,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  en, up_down, clear, load, load_val, ovf_clr,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Modulo-MOD up/down counter with prescaler, clear, clamped load, wrap pulse and sticky ovf.
// Define COUNTER_SAT_EN to build a saturating counter that holds at the range limits instead of wrapping.
module counter_updown_mod #(
  parameter int N        = 8,
  parameter int MOD      = 2**N,
  parameter int PRESCALE = 1
) (
  input logic                 clk,
  input logic                 reset,
  counter_updown_mod_if.slave bus
);
  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0]  max_c      = N'(MOD - 1);
  localparam logic [N:0]    mod_c      = (N+1)'(MOD);
  localparam logic [PW-1:0] pre_last_c = PW'(PRESCALE - 1);
`ifdef COUNTER_SAT_EN
  localparam logic          sat_c      = 1'b1;
`else
  localparam logic          sat_c      = 1'b0;
`endif

  logic [N-1:0]  count_r, count_nx_s;
  logic [PW-1:0] pre_r, pre_nx_s;
  logic          wrap_r, wrap_nx_s;
  logic          ovf_r, ovf_nx_s;
  logic          tick_s;
  logic          at_edge_s;
  logic          boundary_s;

  assign tick_s     = bus.en && (pre_r == pre_last_c);
  assign at_edge_s  = bus.up_down ? (count_r == max_c) : (count_r == {N{1'b0}});
  assign boundary_s = tick_s && at_edge_s;

  // Next-state selection: clear beats load, load beats a prescaled step.
  always_comb begin
    count_nx_s = count_r;
    pre_nx_s   = pre_r;
    wrap_nx_s  = 1'b0;
    ovf_nx_s   = ovf_r;
    if (bus.clear) begin
      count_nx_s = {N{1'b0}};
      pre_nx_s   = {PW{1'b0}};
      ovf_nx_s   = 1'b0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} < mod_c) begin
        count_nx_s = bus.load_val;
      end else begin
        count_nx_s = max_c;
      end
      pre_nx_s = {PW{1'b0}};
      if (bus.ovf_clr) begin
        ovf_nx_s = 1'b0;
      end else begin
        ovf_nx_s = ovf_r;
      end
    end else begin
      if (tick_s) begin
        pre_nx_s = {PW{1'b0}};
      end else if (bus.en) begin
        pre_nx_s = pre_r + PW'(1);
      end else begin
        pre_nx_s = pre_r;
      end

      if (!tick_s) begin
        count_nx_s = count_r;
      end else if (bus.up_down) begin
        count_nx_s = at_edge_s ? (sat_c ? max_c : {N{1'b0}}) : (count_r + N'(1));
      end else begin
        count_nx_s = at_edge_s ? (sat_c ? {N{1'b0}} : max_c) : (count_r - N'(1));
      end

      // A boundary step sets ovf even if ovf_clr is asserted in the same cycle.
      if (boundary_s) begin
        wrap_nx_s = 1'b1;
        ovf_nx_s  = 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_nx_s = 1'b0;
      end else begin
        ovf_nx_s = ovf_r;
      end
    end
  end

  // State registers; the asynchronous reset zeroes everything without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {N{1'b0}};
      pre_r   <= {PW{1'b0}};
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nx_s;
      pre_r   <= pre_nx_s;
      wrap_r  <= wrap_nx_s;
      ovf_r   <= ovf_nx_s;
    end
  end

  assign bus.count = count_r;
  assign bus.tc    = at_edge_s;
  assign bus.wrap  = wrap_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: two instances (PRESCALE 1 and 4, N=4, MOD=10) share stimulus and are
// compared every cycle against an arithmetic reference model; directed phases follow the test plan.
module tb_counter_updown_mod;
  localparam int N   = 4;
  localparam int MOD = 10;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en_v, ud_v, clr_v, ld_v, ovc_v;
  logic [N-1:0] lv_v;

  int checks = 0;
  int errors = 0;

  int ps_m   [2];
  int m_cnt  [2];
  int m_pre  [2];
  int m_wrap [2];
  int m_ovf  [2];

  always #5 clk = ~clk;

  counter_updown_mod_if #(.N(N)) bus0 ();
  counter_updown_mod_if #(.N(N)) bus1 ();

  assign bus0.en = en_v;  assign bus0.up_down = ud_v;  assign bus0.clear = clr_v;
  assign bus0.load = ld_v; assign bus0.load_val = lv_v; assign bus0.ovf_clr = ovc_v;
  assign bus1.en = en_v;  assign bus1.up_down = ud_v;  assign bus1.clear = clr_v;
  assign bus1.load = ld_v; assign bus1.load_val = lv_v; assign bus1.ovf_clr = ovc_v;

  counter_updown_mod #(.N(N), .MOD(MOD), .PRESCALE(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  counter_updown_mod #(.N(N), .MOD(MOD), .PRESCALE(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Reference behaviour for one rising edge, from the counting rules in plain integer arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit tick, hit;
      tick = 1'b0;
      hit  = 1'b0;
      m_wrap[i] = 0;
      if (clr_v) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
      end else if (ld_v) begin
        m_cnt[i] = (int'(lv_v) < MOD) ? int'(lv_v) : MOD - 1;
        m_pre[i] = 0;
        if (ovc_v) m_ovf[i] = 0;
      end else begin
        if (en_v) begin
          m_pre[i]++;
          if (m_pre[i] == ps_m[i]) begin
            m_pre[i] = 0;
            tick = 1'b1;
          end
        end
        if (tick) begin
          if (ud_v) begin
            hit = (m_cnt[i] + 1 == MOD);
            m_cnt[i] = hit ? (SAT ? m_cnt[i] : 0) : m_cnt[i] + 1;
          end else begin
            hit = (m_cnt[i] == 0);
            m_cnt[i] = hit ? (SAT ? 0 : MOD - 1) : m_cnt[i] - 1;
          end
        end
        if (hit) begin
          m_wrap[i] = 1; m_ovf[i] = 1;
        end else if (ovc_v) begin
          m_ovf[i] = 0;
        end
      end
    end
  endtask

  function automatic int model_tc(int cnt);
    return (ud_v && cnt == MOD - 1) || (!ud_v && cnt == 0);
  endfunction

  task automatic check_all();
    chk("count0", 32'(bus0.count), 32'(m_cnt[0]));
    chk("tc0",    32'(bus0.tc),    32'(model_tc(m_cnt[0])));
    chk("wrap0",  32'(bus0.wrap),  32'(m_wrap[0]));
    chk("ovf0",   32'(bus0.ovf),   32'(m_ovf[0]));
    chk("count1", 32'(bus1.count), 32'(m_cnt[1]));
    chk("tc1",    32'(bus1.tc),    32'(model_tc(m_cnt[1])));
    chk("wrap1",  32'(bus1.wrap),  32'(m_wrap[1]));
    chk("ovf1",   32'(bus1.ovf),   32'(m_ovf[1]));
  endtask

  // Inputs are set at the falling edge before calling; model follows the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic en, input logic ud, input logic clr, input logic ld,
                        input logic [N-1:0] lv, input logic ovc);
    en_v = en; ud_v = ud; clr_v = clr; ld_v = ld; lv_v = lv; ovc_v = ovc;
  endtask

  // Pulls reset low between edges and checks that everything clears before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("async.count0", 32'(bus0.count), 32'd0);
    chk("async.ovf0",   32'(bus0.ovf),   32'd0);
    chk("async.wrap0",  32'(bus0.wrap),  32'd0);
    chk("async.count1", 32'(bus1.count), 32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    ps_m[0] = 1;
    ps_m[1] = 4;
    model_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.count0", 32'(bus0.count), 32'd0);
    chk("reset.ovf0",   32'(bus0.ovf),   32'd0);
    check_all();
    reset = 1'b1;

    // Up count through the terminal value.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 12; k++) cycle();
    chk("t1.count0", 32'(bus0.count), 32'd2);
    chk("t1.ovf0",   32'(bus0.ovf),   32'd1);

    // Load then count down through zero.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 4; k++) cycle();
    chk("t2.count0", 32'(bus0.count), 32'd8);

    // Clamped load, then clear beating load.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 1'b0);
    cycle();
    chk("t3.clamp0", 32'(bus0.count), 32'd9);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
    cycle();
    chk("t3.clr.count0", 32'(bus0.count), 32'd0);
    chk("t3.clr.ovf0",   32'(bus0.ovf),   32'd0);

    // Prescaler of 4 holds across disabled cycles.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 8; k++) cycle();
    chk("t4.count1.a", 32'(bus1.count), 32'd2);
    en_v = 1'b0;
    for (int k = 0; k < 2; k++) cycle();
    en_v = 1'b1;
    for (int k = 0; k < 2; k++) cycle();
    chk("t4.count1.b", 32'(bus1.count), 32'd2);
    for (int k = 0; k < 2; k++) cycle();
    chk("t4.count1.c", 32'(bus1.count), 32'd3);

    // Wrap with simultaneous ovf_clr keeps ovf, then async reset at count=7.
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    cycle();
    chk("t5.wrap0", 32'(bus0.wrap), 32'd1);
    chk("t5.ovf0",  32'(bus0.ovf),  32'd1);
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
    cycle();
    chk("t5.pre.count0", 32'(bus0.count), 32'd7);
    chk("t5.pre.ovf0",   32'(bus0.ovf),   32'd1);
    ld_v = 1'b0;
    async_reset();

    // Boundary behaviour of the build variant.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0);
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 4; k++) cycle();
    chk("t6.up.count0", 32'(bus0.count), SAT ? 32'd9 : 32'd2);
    chk("t6.up.ovf0",   32'(bus0.ovf),   32'd1);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 2; k++) cycle();
    chk("t6.dn.count0", 32'(bus0.count), SAT ? 32'd0 : 32'd8);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      en_v  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(7, 0) == 0) ud_v = ~ud_v;
      clr_v = ($urandom_range(31, 0) == 0);
      ld_v  = ($urandom_range(11, 0) == 0);
      lv_v  = N'($urandom_range(15, 0));
      ovc_v = ($urandom_range(9, 0) == 0);
      if ($urandom_range(299, 0) == 0) async_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
